// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the operand width itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff = a - b - cin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b ^ cin;
    bout = (~a & b) | (~(a ^ b) & cin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock in RUN.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_diff;
  logic             fs_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep them aside.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (br_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = fs_bout;
        res_d  = {fs_diff, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        // Publish on the final bit so the outputs change exactly as DONE is entered.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {fs_diff, res_q[WIDTH-1:1]};
          bout_d  = fs_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle. Operands are scrambled
  // right after capture so any late sensitivity to a/b/bin would show up.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output logic [7:0] r_diff, output logic r_bout, output logic r_ovf,
                        output int lat, output int busy_n, output int done_n,
                        output logic [7:0] hold_diff);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
    lat = 1; busy_n = 0; done_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    r_diff = diff; r_bout = bout; r_ovf = ovf;
    if (done) done_n++;
    @(posedge clk); #1;
    if (done) done_n++;
    hold_diff = diff;
  endtask

  logic [7:0] r_diff, hold_diff;
  logic       r_bout, r_ovf;
  int         lat, busy_n, done_n;
  int         done_cnt, first_done, second_done, idx;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'hA5, 8'h0F, 1'b1, 8'h95, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, r_diff, r_bout, r_ovf, lat, busy_n, done_n, hold_diff);
      $display("[TB] vec %0d: %02h - %02h - %0d -> diff=%02h bout=%0d lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bin, r_diff, r_bout, lat, busy_n);
      check($sformatf("vec%0d_diff", i), r_diff, vecs[i].exp_diff);
      check($sformatf("vec%0d_bout", i), r_bout, vecs[i].exp_bout);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 8);
      check($sformatf("vec%0d_done_width", i), done_n, 1);
      check($sformatf("vec%0d_hold", i), hold_diff, vecs[i].exp_diff);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check($sformatf("vec%0d_ovf", i), r_ovf, vecs[i].exp_ovf);
`endif
    end

    // Start pulsed mid-RUN with different operands must be ignored.
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; r_diff = '0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin done_cnt++; r_diff = diff; end
      @(posedge clk); #1;
    end
    $display("[TB] start-in-RUN: dones=%0d diff=%02h", done_cnt, r_diff);
    check("ignore_start_dones", done_cnt, 1);
    check("ignore_start_diff", r_diff, 8'h02);
    check("ignore_start_final_diff", diff, 8'h02);

    // Start held high: second operation accepted in the IDLE cycle after DONE.
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    first_done = -1; second_done = -1; done_cnt = 0;
    for (idx = 1; idx <= 25; idx++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = idx;
        else if (second_done < 0) second_done = idx;
      end
    end
    start = 1'b0;
    $display("[TB] back-to-back: dones at %0d and %0d, diff=%02h", first_done, second_done, diff);
    check("b2b_first_done", first_done, 9);
    check("b2b_second_done", second_done, 19);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_diff", diff, 8'h0F);
    repeat (15) @(posedge clk);
    #1;

    // Reset on the 4th RUN cycle aborts with no done pulse.
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] abort: busy=%0d done=%0d diff=%02h bout=%0d", busy, done, diff, bout);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("abort_ovf", ovf, 0);
`endif
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("abort_stays_idle", done_cnt, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_priority_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_priority_busy2", busy, 0);

    // First start in the very first cycle after reset deasserts.
    rst = 1'b0;
    run_op(8'hFF, 8'h01, 1'b0, r_diff, r_bout, r_ovf, lat, busy_n, done_n, hold_diff);
    $display("[TB] post-reset: FF - 01 -> diff=%02h bout=%0d lat=%0d", r_diff, r_bout, lat);
    check("post_rst_diff", r_diff, 8'hFE);
    check("post_rst_bout", r_bout, 0);
    check("post_rst_latency", lat, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
